sva_attempt_scheduler: RTL and testbench
========================================

SVA_ATTEMPT_SCHEDULER -- requirements
Module: sva_attempt_scheduler

Interface
REQ-001 SHALL have parameter SLOTS, default 4: number of concurrent attempt slots (2..16).
REQ-002 SHALL have parameter STATE_W, default 4: width of the evaluator state code.
REQ-003 SHALL have parameter TS_W, default 8: width of the tick timestamp counter.
REQ-004 SHALL have port gclk  in  1  user clock; all logic is on its rising edge.
REQ-005 SHALL have port grst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port tick  in  1  sample strobe; one evaluation round is requested per tick.
REQ-007 SHALL have port start_en  in  1  launch a new attempt this round; sampled with tick.
REQ-008 SHALL have ports eval_req out 1 and eval_state out STATE_W: request to the shared evaluator and the state to evaluate.
REQ-009 SHALL have ports eval_ack in 1, eval_next in STATE_W, eval_active in 1, eval_succ in 1, eval_fail in 1: evaluator response, valid only with eval_ack.
REQ-010 SHALL have ports succ_pulse, fail_pulse, overflow, overrun  out  1 each: single-cycle event pulses.
REQ-011 SHALL have ports succ_latency out TS_W (valid with succ_pulse), busy out 1, active_cnt out $clog2(SLOTS)+1.

Function
REQ-012 SHALL keep a slot table: valid, state[STATE_W], start_ts[TS_W] per slot.
REQ-013 SHALL increment timestamp ts by 1 on every accepted tick, modulo 2^TS_W.
REQ-014 SHALL implement FSM IDLE, SCAN, WAIT, LAUNCH, LWAIT; busy = (state != IDLE).
REQ-015 IDLE: on tick, snapshot slot valid bits into scan mask, latch start_en, set scan index 0, go SCAN.
REQ-016 A tick outside IDLE SHALL be ignored (no ts increment) and SHALL pulse overrun the next cycle.
REQ-017 SCAN: lowest slot set in scan mask at index >= scan index -> assert eval_req with that slot's state, go WAIT; none -> go LAUNCH.
REQ-018 WAIT: eval_req held high until the cycle eval_ack=1; on ack clear the slot's mask bit, deassert eval_req next cycle, return to SCAN.
REQ-019 On ack in WAIT: eval_active=1 -> slot.state <= eval_next; eval_active=0 -> slot.valid <= 0.
REQ-020 eval_succ with ack SHALL pulse succ_pulse and drive succ_latency = ts - slot.start_ts (mod 2^TS_W); eval_fail pulses fail_pulse; both set -> succ wins, fail suppressed.
REQ-021 LAUNCH: latched start_en=0 -> IDLE; else no free slot -> pulse overflow, go IDLE; else request eval_state=0 (initial state), go LWAIT.
REQ-022 LWAIT: on ack, if eval_active, write lowest free slot {1, eval_next, ts}; apply REQ-020 with latency 0; go IDLE.
REQ-023 Free-slot choice SHALL be made in LAUNCH and reused in LWAIT; slots freed during the same round are eligible.
REQ-024 Slots launched in a round SHALL NOT be evaluated again in that round (snapshot mask).
REQ-025 eval_ack while eval_req=0 SHALL be ignored; ack in the same cycle req rises SHALL be accepted.
REQ-026 active_cnt SHALL equal the popcount of slot valid bits, registered, updated the cycle after any change.
REQ-027 All outputs SHALL be registered; pulses SHALL last exactly one gclk cycle.

Reset
REQ-028 grst SHALL asynchronously clear all slots, ts=0, FSM=IDLE, eval_req=0, eval_state=0, all pulses 0, succ_latency=0, busy=0, active_cnt=0.
REQ-029 grst asserted mid-round SHALL abandon the round; a pending eval_ack after release SHALL be ignored.
REQ-030 First tick after grst release SHALL be accepted normally with ts 0 -> 1.

Verification
REQ-031 Single attempt: tick+start_en, evaluator returns next=1 active; then 2 ticks returning next=2, then succ -> succ_pulse with succ_latency=2, active_cnt 1->0.
REQ-032 Fill: SLOTS=4, 5 consecutive ticks with start_en, evaluator always active non-terminal -> active_cnt=4, overflow pulse on 5th round only.
REQ-033 Overrun: tick again while busy (evaluator ack delayed 10 cycles) -> overrun pulse, ts advances once only.
REQ-034 Fail+succ same ack -> succ_pulse=1, fail_pulse=0; eval_fail alone with active=0 -> fail_pulse, slot freed, reused by next launch.
REQ-035 Immediate launch success: initial evaluation returns succ, active=0 -> succ_pulse, succ_latency=0, active_cnt stays 0.
REQ-036 Reset in WAIT with eval_req high -> eval_req=0 at once, active_cnt=0, late ack ignored.

Source files
------------

// File: rtl/sva_attempt_scheduler.sv
// Time-multiplexes one shared property evaluator across SLOTS concurrent assertion attempts.
// Each accepted tick runs one round: evaluate every live slot once, then optionally launch a new attempt.
module sva_attempt_scheduler #(
    parameter int SLOTS   = 4,
    parameter int STATE_W = 4,
    parameter int TS_W    = 8
) (
    input  logic                   gclk,
    input  logic                   grst,
    input  logic                   tick,
    input  logic                   start_en,
    output logic                   eval_req,
    output logic [STATE_W-1:0]     eval_state,
    input  logic                   eval_ack,
    input  logic [STATE_W-1:0]     eval_next,
    input  logic                   eval_active,
    input  logic                   eval_succ,
    input  logic                   eval_fail,
    output logic                   succ_pulse,
    output logic                   fail_pulse,
    output logic                   overflow,
    output logic                   overrun,
    output logic [TS_W-1:0]        succ_latency,
    output logic                   busy,
    output logic [$clog2(SLOTS):0] active_cnt
);
    localparam int IDX_W = $clog2(SLOTS);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [2:0] {IDLE, SCAN, WAIT, LAUNCH, LWAIT} state_t;
    state_t state;

    logic [SLOTS-1:0]   slot_valid;
    logic [STATE_W-1:0] slot_state [SLOTS];
    logic [TS_W-1:0]    slot_ts    [SLOTS];
    logic [TS_W-1:0]    ts;
    logic [SLOTS-1:0]   scan_mask;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   launch_slot;
    logic               start_lat;

    logic               scan_hit;
    logic [IDX_W-1:0]   scan_sel;
    logic               free_hit;
    logic [IDX_W-1:0]   free_sel;
    logic [CNT_W-1:0]   valid_cnt;

    // Descending loops so the lowest qualifying index wins.
    always_comb begin
        scan_hit  = 1'b0;
        scan_sel  = '0;
        free_hit  = 1'b0;
        free_sel  = '0;
        valid_cnt = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (scan_mask[i] && (IDX_W'(i) >= scan_idx)) begin
                scan_hit = 1'b1;
                scan_sel = IDX_W'(i);
            end
            if (!slot_valid[i]) begin
                free_hit = 1'b1;
                free_sel = IDX_W'(i);
            end
            valid_cnt = valid_cnt + CNT_W'(slot_valid[i]);
        end
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state        <= IDLE;
            slot_valid   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_state[i] <= '0;
                slot_ts[i]    <= '0;
            end
            ts           <= '0;
            scan_mask    <= '0;
            scan_idx     <= '0;
            launch_slot  <= '0;
            start_lat    <= 1'b0;
            eval_req     <= 1'b0;
            eval_state   <= '0;
            succ_pulse   <= 1'b0;
            fail_pulse   <= 1'b0;
            overflow     <= 1'b0;
            overrun      <= 1'b0;
            succ_latency <= '0;
            busy         <= 1'b0;
            active_cnt   <= '0;
        end else begin
            succ_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            overflow   <= 1'b0;
            overrun    <= tick && (state != IDLE);
            active_cnt <= valid_cnt;

            case (state)
                IDLE: begin
                    if (tick) begin
                        ts        <= ts + 1'b1;
                        scan_mask <= slot_valid;
                        start_lat <= start_en;
                        scan_idx  <= '0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_hit) begin
                        scan_idx   <= scan_sel;
                        eval_req   <= 1'b1;
                        eval_state <= slot_state[scan_sel];
                        state      <= WAIT;
                    end else begin
                        state <= LAUNCH;
                    end
                end
                WAIT: begin
                    if (eval_ack && eval_req) begin
                        eval_req            <= 1'b0;
                        scan_mask[scan_idx] <= 1'b0;
                        if (eval_active)
                            slot_state[scan_idx] <= eval_next;
                        else
                            slot_valid[scan_idx] <= 1'b0;
                        if (eval_succ) begin
                            succ_pulse   <= 1'b1;
                            succ_latency <= ts - slot_ts[scan_idx];
                        end else if (eval_fail) begin
                            fail_pulse <= 1'b1;
                        end
                        state <= SCAN;
                    end
                end
                LAUNCH: begin
                    if (!start_lat) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!free_hit) begin
                        overflow <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        launch_slot <= free_sel;
                        eval_req    <= 1'b1;
                        eval_state  <= '0;
                        state       <= LWAIT;
                    end
                end
                LWAIT: begin
                    // A launched attempt only occupies a slot if the evaluator keeps it alive.
                    if (eval_ack && eval_req) begin
                        eval_req <= 1'b0;
                        if (eval_active) begin
                            slot_valid[launch_slot] <= 1'b1;
                            slot_state[launch_slot] <= eval_next;
                            slot_ts[launch_slot]    <= ts;
                        end
                        if (eval_succ) begin
                            succ_pulse   <= 1'b1;
                            succ_latency <= '0;
                        end else if (eval_fail) begin
                            fail_pulse <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sva_attempt_scheduler.sv
// Directed bench for sva_attempt_scheduler; the bench plays the shared evaluator
// and checks requested states, pulses, latencies and slot counts against hand-computed values.
module tb_sva_attempt_scheduler;
    localparam int SLOTS   = 4;
    localparam int STATE_W = 4;
    localparam int TS_W    = 8;

    logic                   gclk = 1'b0;
    logic                   grst;
    logic                   tick;
    logic                   start_en;
    logic                   eval_req;
    logic [STATE_W-1:0]     eval_state;
    logic                   eval_ack;
    logic [STATE_W-1:0]     eval_next;
    logic                   eval_active;
    logic                   eval_succ;
    logic                   eval_fail;
    logic                   succ_pulse;
    logic                   fail_pulse;
    logic                   overflow;
    logic                   overrun;
    logic [TS_W-1:0]        succ_latency;
    logic                   busy;
    logic [$clog2(SLOTS):0] active_cnt;

    sva_attempt_scheduler #(.SLOTS(SLOTS), .STATE_W(STATE_W), .TS_W(TS_W)) dut (
        .gclk(gclk), .grst(grst), .tick(tick), .start_en(start_en),
        .eval_req(eval_req), .eval_state(eval_state), .eval_ack(eval_ack),
        .eval_next(eval_next), .eval_active(eval_active), .eval_succ(eval_succ),
        .eval_fail(eval_fail), .succ_pulse(succ_pulse), .fail_pulse(fail_pulse),
        .overflow(overflow), .overrun(overrun), .succ_latency(succ_latency),
        .busy(busy), .active_cnt(active_cnt)
    );

    always #5 gclk = ~gclk;

    int passCount  = 0;
    int checkCount = 0;
    int succCount  = 0;
    int failCount  = 0;
    int ovfCount   = 0;
    int ovrCount   = 0;
    int base;
    logic sp, fp;
    logic [TS_W-1:0] lat;

    // Pulse counters double as a single-cycle check: a stuck pulse inflates the count.
    always @(negedge gclk) begin
        if (succ_pulse) succCount++;
        if (fail_pulse) failCount++;
        if (overflow)   ovfCount++;
        if (overrun)    ovrCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic st);
        @(negedge gclk);
        tick     = 1'b1;
        start_en = st;
        @(negedge gclk);
        tick     = 1'b0;
        start_en = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            @(negedge gclk);
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic serveEval(input string tag, input logic [STATE_W-1:0] expState,
                             input logic act, input logic [STATE_W-1:0] nxt,
                             input logic succ, input logic fail, input int delay,
                             input bit injectTick, output logic spo, output logic fpo,
                             output logic [TS_W-1:0] lato);
        int n = 0;
        spo = 1'b0; fpo = 1'b0; lato = '0;
        while (eval_req !== 1'b1 && n < 50) begin
            @(negedge gclk);
            n++;
        end
        if (eval_req !== 1'b1) begin
            checkOutput({tag, "_req"}, 32'(eval_req), 32'd1);
            return;
        end
        checkOutput({tag, "_state"}, 32'(eval_state), 32'(expState));
        for (int i = 0; i < delay; i++) begin
            tick = injectTick && (i == 2);
            @(negedge gclk);
        end
        tick        = 1'b0;
        eval_ack    = 1'b1;
        eval_active = act;
        eval_next   = nxt;
        eval_succ   = succ;
        eval_fail   = fail;
        @(negedge gclk);
        spo  = succ_pulse;
        fpo  = fail_pulse;
        lato = succ_latency;
        eval_ack = 1'b0; eval_active = 1'b0; eval_next = '0; eval_succ = 1'b0; eval_fail = 1'b0;
    endtask

    initial begin
        grst = 1'b1; tick = 1'b0; start_en = 1'b0; eval_ack = 1'b0;
        eval_next = '0; eval_active = 1'b0; eval_succ = 1'b0; eval_fail = 1'b0;
        repeat (3) @(negedge gclk);
        checkOutput("rst_req", 32'(eval_req), 0);
        checkOutput("rst_state", 32'(eval_state), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_cnt", 32'(active_cnt), 0);
        checkOutput("rst_lat", 32'(succ_latency), 0);
        grst = 1'b0;

        // Single attempt: launch at ts=1, succeed at ts=3.
        applyStimulus(1);
        serveEval("a_launch", 0, 1, 1, 0, 0, 0, 0, sp, fp, lat);
        waitIdle("a1");
        @(negedge gclk);
        checkOutput("a_cnt1", 32'(active_cnt), 1);
        applyStimulus(0);
        serveEval("a_step", 1, 1, 2, 0, 0, 0, 0, sp, fp, lat);
        waitIdle("a2");
        applyStimulus(0);
        serveEval("a_succ", 2, 0, 0, 1, 0, 0, 0, sp, fp, lat);
        checkOutput("a_sp", 32'(sp), 1);
        checkOutput("a_lat", 32'(lat), 2);
        waitIdle("a3");
        @(negedge gclk);
        checkOutput("a_cnt0", 32'(active_cnt), 0);

        // Fill four slots over rounds ts=4..7; the fifth round overflows.
        for (int r = 1; r <= 5; r++) begin
            base = ovfCount;
            applyStimulus(1);
            for (int s = 0; s < r - 1; s++) serveEval("c_scan", 5, 1, 5, 0, 0, 0, 0, sp, fp, lat);
            if (r <= 4) serveEval("c_launch", 0, 1, 5, 0, 0, 0, 0, sp, fp, lat);
            waitIdle("c");
            #1;
            checkOutput("c_overflow", 32'(ovfCount - base), (r == 5) ? 32'd1 : 32'd0);
        end
        @(negedge gclk);
        checkOutput("c_cnt4", 32'(active_cnt), 4);

        // ts=9: succ+fail on slot0, plain fail frees slot1, which the launch reuses.
        base = failCount;
        applyStimulus(1);
        serveEval("e_s0", 5, 1, 5, 1, 1, 0, 0, sp, fp, lat);
        checkOutput("e_s0_sp", 32'(sp), 1);
        checkOutput("e_s0_fp", 32'(fp), 0);
        checkOutput("e_s0_lat", 32'(lat), 5);
        serveEval("e_s1", 5, 0, 0, 0, 1, 0, 0, sp, fp, lat);
        checkOutput("e_s1_fp", 32'(fp), 1);
        checkOutput("e_s1_sp", 32'(sp), 0);
        serveEval("e_s2", 5, 1, 5, 0, 0, 0, 0, sp, fp, lat);
        serveEval("e_s3", 5, 1, 5, 0, 0, 0, 0, sp, fp, lat);
        serveEval("e_launch", 0, 1, 7, 0, 0, 0, 0, sp, fp, lat);
        waitIdle("e1");
        @(negedge gclk);
        #1;
        checkOutput("e_fails", 32'(failCount - base), 1);
        checkOutput("e_cnt4", 32'(active_cnt), 4);
        applyStimulus(0);
        serveEval("e2_s0", 5, 1, 5, 0, 0, 0, 0, sp, fp, lat);
        serveEval("e2_s1", 7, 0, 0, 1, 0, 0, 0, sp, fp, lat);
        checkOutput("e2_lat", 32'(lat), 1);
        serveEval("e2_s2", 5, 1, 5, 0, 0, 0, 0, sp, fp, lat);
        serveEval("e2_s3", 5, 1, 5, 0, 0, 0, 0, sp, fp, lat);
        waitIdle("e2");
        @(negedge gclk);
        checkOutput("e2_cnt3", 32'(active_cnt), 3);

        // Reset while a request is outstanding; a late ack must be ignored.
        applyStimulus(0);
        for (int n = 0; n < 50 && eval_req !== 1'b1; n++) @(negedge gclk);
        checkOutput("g_req_hi", 32'(eval_req), 1);
        #1;
        grst = 1'b1;
        #1;
        checkOutput("g_req_lo", 32'(eval_req), 0);
        checkOutput("g_busy", 32'(busy), 0);
        checkOutput("g_cnt", 32'(active_cnt), 0);
        base = succCount;
        eval_ack = 1'b1; eval_active = 1'b1; eval_succ = 1'b1;
        repeat (2) @(negedge gclk);
        grst = 1'b0;
        repeat (3) @(negedge gclk);
        #1;
        checkOutput("g_late_req", 32'(eval_req), 0);
        checkOutput("g_late_busy", 32'(busy), 0);
        checkOutput("g_late_succ", 32'(succCount - base), 0);
        eval_ack = 1'b0; eval_active = 1'b0; eval_succ = 1'b0;

        // After reset: launch at ts=1, then an overrun tick during a delayed ack must not bump ts.
        applyStimulus(1);
        serveEval("d_launch", 0, 1, 3, 0, 0, 0, 0, sp, fp, lat);
        waitIdle("d1");
        base = ovrCount;
        applyStimulus(0);
        serveEval("d_ovr", 3, 0, 0, 1, 0, 10, 1, sp, fp, lat);
        checkOutput("d_sp", 32'(sp), 1);
        checkOutput("d_lat", 32'(lat), 1);
        waitIdle("d2");
        #1;
        checkOutput("d_overrun", 32'(ovrCount - base), 1);

        // Launch that succeeds immediately never occupies a slot.
        applyStimulus(1);
        serveEval("f_launch", 0, 0, 0, 1, 0, 0, 0, sp, fp, lat);
        checkOutput("f_sp", 32'(sp), 1);
        checkOutput("f_lat", 32'(lat), 0);
        waitIdle("f");
        repeat (2) @(negedge gclk);
        checkOutput("f_cnt0", 32'(active_cnt), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
